alu_writeback_stage: RTL and testbench



---
 rtl/alu_writeback_stage_pkg.sv | 37 +++
 rtl/alu_writeback_stage_if.sv | 36 +++
 rtl/alu_writeback_stage_fifo.sv | 71 +++++++
 rtl/alu_writeback_stage.sv | 153 +++++++++++++++
 tb/tb_alu_writeback_stage.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_writeback_stage_pkg.sv
// Shared types and widths for the ALU writeback stage: the sequencer
// state encoding, the buffered result entry, and a register-index helper.
package pkg_wb;

  localparam int DATA_WIDTH    = 8;
  localparam int FLAGS_WIDTH   = 4;
  localparam int REG_IDX_WIDTH = 4;
  localparam int FIFO_DEPTH    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2,
    NO_WR = 2'd3
  } wb_state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0]    res_lo;
    logic [DATA_WIDTH-1:0]    res_hi;
    logic [FLAGS_WIDTH-1:0]   flags;
    logic [REG_IDX_WIDTH-1:0] dest;
    logic                     is_pair;
    logic                     wr_result;
    logic                     wr_flags;
  } wb_entry;

  // Register index for one byte of a result. Pairs are aligned down to an
  // even/odd register couple; single bytes keep their index unchanged.
  function automatic logic [REG_IDX_WIDTH-1:0] byte_addr(
    input logic [REG_IDX_WIDTH-1:0] dest,
    input logic                     is_pair,
    input logic                     hi_byte
  );
    return {dest[REG_IDX_WIDTH-1:1], hi_byte | (dest[0] & ~is_pair)};
  endfunction

endpackage

// File: rtl/alu_writeback_stage_if.sv
// Result-input handshake and register-file write bus of the writeback stage.
// Handshake: a result transfers on a rising clk edge where in_valid and
// in_ready are both 1; in_ready depends only on registered state, never on
// in_valid, and the producer must hold the result stable while in_valid is 1
// and in_ready is 0.
interface alu_writeback_stage_if;
  import pkg_wb::*;

  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_WIDTH-1:0]    in_res_lo;
  logic [DATA_WIDTH-1:0]    in_res_hi;
  logic [FLAGS_WIDTH-1:0]   in_flags;
  logic [REG_IDX_WIDTH-1:0] in_dest;
  logic                     in_is_pair;
  logic                     in_wr_result;
  logic                     in_wr_flags;
  logic                     rf_wr_en;
  logic [REG_IDX_WIDTH-1:0] rf_wr_addr;
  logic [DATA_WIDTH-1:0]    rf_wr_data;

  // ALU / bench side
  modport master (
    output in_valid, in_res_lo, in_res_hi, in_flags, in_dest,
           in_is_pair, in_wr_result, in_wr_flags,
    input  in_ready, rf_wr_en, rf_wr_addr, rf_wr_data
  );

  // Writeback stage side
  modport slave (
    input  in_valid, in_res_lo, in_res_hi, in_flags, in_dest,
           in_is_pair, in_wr_result, in_wr_flags,
    output in_ready, rf_wr_en, rf_wr_addr, rf_wr_data
  );

endinterface

// File: rtl/alu_writeback_stage_fifo.sv
// Small synchronous FIFO of writeback entries. Flush empties it and wins
// over a simultaneous push or pop. DEPTH must be a power of two so the
// pointers wrap naturally.
module wb_result_fifo
  import pkg_wb::*;
#(
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    flush,
  input  logic    push,
  input  wb_entry push_data,
  input  logic    pop,
  output wb_entry pop_data,
  output logic    full,
  output logic    empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry         mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and occupancy update
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (do_push && !do_pop)      count_d = count_q + CW'(1);
      else if (do_pop && !do_push) count_d = count_q - CW'(1);
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while empty so no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/alu_writeback_stage.sv
// Writeback stage behind the ALU: buffers results, sequences them onto the
// single byte-wide register-file write port (two cycles for pairs) and owns
// the architectural flags register that feeds back into the ALU.
module alu_writeback_stage
  import pkg_wb::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  alu_writeback_stage_if.slave   wb,
  output logic [FLAGS_WIDTH-1:0] proc_flags,
  output logic                   busy,
  output wb_state_e              dbg_state
);

  wb_entry   head;
  wb_entry   push_entry;
  logic      fifo_full;
  logic      fifo_empty;
  logic      pop;
  logic      finishing;

  wb_state_e                state_q, state_d;
  logic                     rf_wr_en_q, rf_wr_en_d;
  logic [REG_IDX_WIDTH-1:0] rf_wr_addr_q, rf_wr_addr_d;
  logic [DATA_WIDTH-1:0]    rf_wr_data_q, rf_wr_data_d;
  logic [FLAGS_WIDTH-1:0]   proc_flags_q, proc_flags_d;
  // Working copy of the entry being written; only what later cycles need
  logic [DATA_WIDTH-1:0]    cur_hi_q, cur_hi_d;
  logic [REG_IDX_WIDTH-1:0] cur_hi_addr_q, cur_hi_addr_d;
  logic                     cur_pair_q, cur_pair_d;
  logic [FLAGS_WIDTH-1:0]   cur_flags_q, cur_flags_d;
  logic                     cur_wr_flags_q, cur_wr_flags_d;

  assign push_entry = '{
    res_lo:    wb.in_res_lo,
    res_hi:    wb.in_res_hi,
    flags:     wb.in_flags,
    dest:      wb.in_dest,
    is_pair:   wb.in_is_pair,
    wr_result: wb.in_wr_result,
    wr_flags:  wb.in_wr_flags
  };

  wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .push      (wb.in_valid),
    .push_data (push_entry),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // The current entry ends this cycle: single-byte write, hi byte, or no-write
  assign finishing = (state_q == WR_LO && !cur_pair_q) ||
                     (state_q == WR_HI) || (state_q == NO_WR);
  assign pop       = !fifo_empty && !flush && (state_q == IDLE || finishing);

  // Sequencer next state, registered write-port outputs and flags commit
  always_comb begin
    state_d        = state_q;
    rf_wr_en_d     = 1'b0;
    rf_wr_addr_d   = rf_wr_addr_q;
    rf_wr_data_d   = rf_wr_data_q;
    proc_flags_d   = proc_flags_q;
    cur_hi_d       = cur_hi_q;
    cur_hi_addr_d  = cur_hi_addr_q;
    cur_pair_d     = cur_pair_q;
    cur_flags_d    = cur_flags_q;
    cur_wr_flags_d = cur_wr_flags_q;

    if (finishing && cur_wr_flags_q) proc_flags_d = cur_flags_q;

    case (state_q)
      IDLE: state_d = IDLE;
      WR_LO: begin
        if (cur_pair_q) begin
          state_d      = WR_HI;
          rf_wr_en_d   = 1'b1;
          rf_wr_addr_d = cur_hi_addr_q;
          rf_wr_data_d = cur_hi_q;
        end else begin
          state_d = IDLE;
        end
      end
      WR_HI:   state_d = IDLE;
      NO_WR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Load the next entry straight from the FIFO head so entries run back to back
    if (pop) begin
      cur_hi_d       = head.res_hi;
      cur_hi_addr_d  = byte_addr(head.dest, head.is_pair, 1'b1);
      cur_pair_d     = head.is_pair;
      cur_flags_d    = head.flags;
      cur_wr_flags_d = head.wr_flags;
      if (head.wr_result) begin
        state_d      = WR_LO;
        rf_wr_en_d   = 1'b1;
        rf_wr_addr_d = byte_addr(head.dest, head.is_pair, 1'b0);
        rf_wr_data_d = head.res_lo;
      end else begin
        state_d = NO_WR;
      end
    end

    if (flush) begin
      state_d      = IDLE;
      rf_wr_en_d   = 1'b0;
      proc_flags_d = proc_flags_q;
    end
  end

  // Sequencer state and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      rf_wr_en_q     <= 1'b0;
      rf_wr_addr_q   <= '0;
      rf_wr_data_q   <= '0;
      proc_flags_q   <= '0;
      cur_hi_q       <= '0;
      cur_hi_addr_q  <= '0;
      cur_pair_q     <= 1'b0;
      cur_flags_q    <= '0;
      cur_wr_flags_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rf_wr_en_q     <= rf_wr_en_d;
      rf_wr_addr_q   <= rf_wr_addr_d;
      rf_wr_data_q   <= rf_wr_data_d;
      proc_flags_q   <= proc_flags_d;
      cur_hi_q       <= cur_hi_d;
      cur_hi_addr_q  <= cur_hi_addr_d;
      cur_pair_q     <= cur_pair_d;
      cur_flags_q    <= cur_flags_d;
      cur_wr_flags_q <= cur_wr_flags_d;
    end
  end

  assign wb.in_ready   = !fifo_full;
  assign wb.rf_wr_en   = rf_wr_en_q;
  assign wb.rf_wr_addr = rf_wr_addr_q;
  assign wb.rf_wr_data = rf_wr_data_q;
  assign proc_flags    = proc_flags_q;
  assign busy          = !fifo_empty || (state_q != IDLE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_writeback_stage.sv
// Directed bench for alu_writeback_stage: expected register-file writes go
// into a queue as results are issued; a negedge monitor pops and compares
// every write the stage presents. Flags, busy and ready are checked inline.
module tb_alu_writeback_stage;
  import pkg_wb::*;

  localparam int W = REG_IDX_WIDTH + DATA_WIDTH;

  logic                   clk;
  logic                   reset_n;
  logic                   flush;
  logic [FLAGS_WIDTH-1:0] proc_flags;
  logic                   busy;
  wb_state_e              dbg_state;

  alu_writeback_stage_if wb_if();

  alu_writeback_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .wb         (wb_if.slave),
    .proc_flags (proc_flags),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  int tests_run    = 0;
  int tests_failed = 0;
  logic [W-1:0] exp_q[$];
  int cyc          = 0;
  int wr_count     = 0;
  int first_wr_cyc = -1;
  int last_wr_cyc  = -1;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers / driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input logic [REG_IDX_WIDTH-1:0] addr, input logic [DATA_WIDTH-1:0] data);
    exp_q.push_back({addr, data});
  endtask

  // Presents a result and returns 1 time unit after the accepting edge.
  // in_valid is left high so consecutive calls stream without gaps.
  task automatic push(input logic [DATA_WIDTH-1:0] lo, input logic [DATA_WIDTH-1:0] hi,
                      input logic [FLAGS_WIDTH-1:0] fl, input logic [REG_IDX_WIDTH-1:0] dest,
                      input logic pair, input logic wr_res, input logic wr_fl,
                      output int stalls);
    @(negedge clk);
    wb_if.in_res_lo    = lo;
    wb_if.in_res_hi    = hi;
    wb_if.in_flags     = fl;
    wb_if.in_dest      = dest;
    wb_if.in_is_pair   = pair;
    wb_if.in_wr_result = wr_res;
    wb_if.in_wr_flags  = wr_fl;
    wb_if.in_valid     = 1'b1;
    stalls = 0;
    while (!wb_if.in_ready && stalls < 20) begin
      stalls++;
      @(negedge clk);
    end
    if (!wb_if.in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL push_timeout: in_ready stayed 0 for %0d cycles, expected 1", stalls);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (busy) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, n);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp;
    cyc++;
    if (reset_n && wb_if.rf_wr_en) begin
      got = {wb_if.rf_wr_addr, wb_if.rf_wr_data};
      wr_count++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      last_wr_cyc = cyc;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL rf_write_unexpected: got addr=%0d data=0x%0h, expected no write",
                 wb_if.rf_wr_addr, wb_if.rf_wr_data);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          tests_failed++;
          $display("FAIL rf_write: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h",
                   got[W-1:DATA_WIDTH], got[DATA_WIDTH-1:0], exp[W-1:DATA_WIDTH], exp[DATA_WIDTH-1:0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int st;
    reset_n            = 1'b0;
    flush              = 1'b0;
    wb_if.in_valid     = 1'b0;
    wb_if.in_res_lo    = '0;
    wb_if.in_res_hi    = '0;
    wb_if.in_flags     = '0;
    wb_if.in_dest      = '0;
    wb_if.in_is_pair   = 1'b0;
    wb_if.in_wr_result = 1'b0;
    wb_if.in_wr_flags  = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Reset state
    check("reset_in_ready",  wb_if.in_ready, 1);
    check("reset_busy",      busy, 0);
    check("reset_rf_wr_en",  wb_if.rf_wr_en, 0);
    check("reset_rf_addr",   wb_if.rf_wr_addr, 0);
    check("reset_rf_data",   wb_if.rf_wr_data, 0);
    check("reset_flags",     proc_flags, 0);
    check("reset_state",     dbg_state, IDLE);

    // 1: single-byte write with flags commit
    expect_wr(4'd3, 8'h5A);
    push(8'h5A, 8'h00, 4'h2, 4'd3, 1'b0, 1'b1, 1'b1, st);
    wb_if.in_valid = 1'b0;
    @(negedge clk);
    check("t1_busy_after_push", busy, 1);
    check("t1_flags_before",    proc_flags, 4'h0);
    @(negedge clk);
    check("t1_flags_during_wr", proc_flags, 4'h0);
    @(negedge clk);
    check("t1_flags_after",     proc_flags, 4'h2);
    check("t1_busy_done",       busy, 0);

    // 2: pair to odd dest aligns down; flags only after hi byte
    expect_wr(4'd4, 8'h34);
    expect_wr(4'd5, 8'h12);
    push(8'h34, 8'h12, 4'h8, 4'd5, 1'b1, 1'b1, 1'b1, st);
    wb_if.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("t2_flags_after_lo", proc_flags, 4'h2);
    @(negedge clk);
    check("t2_flags_after_hi", proc_flags, 4'h8);
    check("t2_busy_done",      busy, 0);

    // 3: compare - flags only, no register write
    push(8'hFF, 8'hFF, 4'h1, 4'd7, 1'b0, 1'b0, 1'b1, st);
    wb_if.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t3_state_no_wr",     dbg_state, NO_WR);
    check("t3_no_wr_en",        wb_if.rf_wr_en, 0);
    check("t3_flags_in_no_wr",  proc_flags, 4'h8);
    @(negedge clk);
    check("t3_flags_after",     proc_flags, 4'h1);
    check("t3_busy_done",       busy, 0);

    // 4: streamed results; FIFO fills, writes stay contiguous and ordered
    wr_count     = 0;
    first_wr_cyc = -1;
    expect_wr(4'd2,  8'h11);
    expect_wr(4'd6,  8'h22);
    expect_wr(4'd7,  8'h33);
    expect_wr(4'd9,  8'h44);
    expect_wr(4'd10, 8'h55);
    expect_wr(4'd15, 8'h66);
    push(8'h11, 8'h00, 4'hF, 4'd2,  1'b0, 1'b1, 1'b0, st);
    push(8'h22, 8'h33, 4'h4, 4'd7,  1'b1, 1'b1, 1'b1, st);
    push(8'h44, 8'h00, 4'hE, 4'd9,  1'b0, 1'b1, 1'b0, st);
    push(8'h55, 8'h00, 4'hD, 4'd10, 1'b0, 1'b1, 1'b0, st);
    push(8'h66, 8'h00, 4'hB, 4'd15, 1'b0, 1'b1, 1'b1, st);
    wb_if.in_valid = 1'b0;
    check("t4_full_stall_cycles", st, 1);
    wait_idle("t4_drain");
    check("t4_write_count", wr_count, 6);
    check("t4_contiguous",  last_wr_cyc - first_wr_cyc + 1, 6);
    check("t4_flags_final", proc_flags, 4'hB);

    // 5: flush during WR_LO of a pair with one entry buffered and a push pending
    expect_wr(4'd12, 8'h77);
    push(8'h77, 8'h88, 4'h5, 4'd12, 1'b1, 1'b1, 1'b1, st);
    push(8'h99, 8'h00, 4'h6, 4'd1,  1'b0, 1'b1, 1'b1, st);
    wb_if.in_res_lo = 8'hEE;
    wb_if.in_flags  = 4'hC;
    wb_if.in_dest   = 4'd14;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    wb_if.in_valid = 1'b0;
    @(negedge clk);
    check("t5_busy_after_flush",  busy, 0);
    check("t5_wr_en_after_flush", wb_if.rf_wr_en, 0);
    check("t5_flags_kept",        proc_flags, 4'hB);
    repeat (5) @(negedge clk);
    check("t5_busy_later",        busy, 0);
    check("t5_flags_later",       proc_flags, 4'hB);

    // 6: asynchronous reset in the middle of WR_HI
    expect_wr(4'd2, 8'hAB);
    push(8'hAB, 8'hCD, 4'h9, 4'd3, 1'b1, 1'b1, 1'b1, st);
    wb_if.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("t6_state_wr_hi", dbg_state, WR_HI);
    check("t6_hi_addr",     wb_if.rf_wr_addr, 4'd3);
    #1;
    reset_n = 1'b0;
    #1;
    check("t6_wr_en_async",   wb_if.rf_wr_en, 0);
    check("t6_flags_async",   proc_flags, 0);
    check("t6_in_ready",      wb_if.in_ready, 1);
    check("t6_busy_async",    busy, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_busy_after",    busy, 0);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
